// File: rtl/switch_input_arbiter.sv
// Round-robin arbiter sharing one switch input port among NUM_REQ packet sources.
// Holds the grant for a whole DA,SA,LENGTH,payload,PARITY frame and inserts idle gaps between frames.
module switch_input_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*8-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             sw_data,
  output logic                   sw_enable,
  output logic [2:0]             grant_id,
  output logic                   busy,
  output logic                   pkt_done,
  output logic                   underrun
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = 9;
  localparam int unsigned GAP_W = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_PAYLOAD,
    S_PARITY,
    S_GAP
  } state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   grant_q;
  logic [IDX_W-1:0]   rr_q;
  logic [7:0]         len_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [GAP_W-1:0]   gap_q;
  logic [7:0]         sw_data_q;
  logic               sw_enable_q;
  logic               pkt_done_q;
  logic               underrun_q;

  logic               xfer;
  logic               accept;
  logic               sel_valid;
  logic [7:0]         sel_data;
  logic               any_valid;
  logic [IDX_W-1:0]   winner_d;
  logic [IDX_W-1:0]   rr_d;
  logic [2*NUM_REQ-1:0] dbl_valid;
  logic [NUM_REQ-1:0] rot_valid;
  int                 win_sum;

  assign xfer   = (state_q == S_HEADER) || (state_q == S_PAYLOAD) || (state_q == S_PARITY);
  assign accept = xfer & sel_valid;

  // Granted requester's byte/valid; ready depends on state and grant only, never on valid.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    req_ready = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_q == IDX_W'(i)) begin
        sel_valid    = req_valid[i];
        sel_data     = req_data[i*8 +: 8];
        req_ready[i] = xfer;
      end
    end
  end

  // Rotate the valid vector so bit 0 is the rr pointer; lowest set offset wins.
  always_comb begin
    dbl_valid = {req_valid, req_valid};
    rot_valid = NUM_REQ'(dbl_valid >> rr_q);
    any_valid = 1'b0;
    win_sum   = int'(rr_q);
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      if (rot_valid[k]) begin
        any_valid = 1'b1;
        win_sum   = int'(rr_q) + k;
      end
    end
    if (win_sum >= int'(NUM_REQ)) begin
      win_sum = win_sum - int'(NUM_REQ);
    end
    winner_d = IDX_W'(win_sum);
    rr_d     = (winner_d == IDX_W'(NUM_REQ - 1)) ? '0 : winner_d + IDX_W'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      rr_q        <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      gap_q       <= '0;
      sw_data_q   <= '0;
      sw_enable_q <= 1'b0;
      pkt_done_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      sw_enable_q <= accept;
      pkt_done_q  <= 1'b0;
      underrun_q  <= xfer & ~sel_valid;
      if (accept) begin
        sw_data_q <= sel_data;
      end
      case (state_q)
        S_IDLE: begin
          if (any_valid) begin
            grant_q <= winner_d;
            rr_q    <= rr_d;
            cnt_q   <= '0;
            state_q <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (accept) begin
            if (cnt_q == CNT_W'(2)) begin
              len_q   <= sel_data;
              cnt_q   <= '0;
              state_q <= (sel_data == 8'd0) ? S_PARITY : S_PAYLOAD;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        S_PAYLOAD: begin
          // 9-bit count so a 255-byte payload terminates without wrapping
          if (accept) begin
            if (cnt_q + CNT_W'(1) == CNT_W'(len_q)) begin
              cnt_q   <= '0;
              state_q <= S_PARITY;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        S_PARITY: begin
          if (accept) begin
            pkt_done_q <= 1'b1;
            gap_q      <= '0;
            state_q    <= (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
          end
        end
        S_GAP: begin
          if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
            gap_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sw_data   = sw_data_q;
  assign sw_enable = sw_enable_q;
  assign grant_id  = 3'(grant_q);
  assign busy      = xfer;
  assign pkt_done  = pkt_done_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_switch_input_arbiter.sv
// Randomized bench for switch_input_arbiter against a frame-level reference model.
module tb_switch_input_arbiter;

  localparam int unsigned NR  = 4;
  localparam int          GAP = 1;

  logic              clock = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR*8-1:0]   req_data;
  logic [NR-1:0]     req_ready;
  logic [7:0]        sw_data;
  logic              sw_enable;
  logic [2:0]        grant_id;
  logic              busy, pkt_done, underrun;

  logic [NR-1:0]     g_valid;
  logic [NR*8-1:0]   g_data;
  logic [NR-1:0]     g0_ready, g3_ready;
  logic [7:0]        g0_data, g3_data;
  logic              g0_en, g3_en, g0_busy, g3_busy, g0_done, g3_done, g0_under, g3_under;
  logic [2:0]        g0_grant, g3_grant;

  always #5 clock = ~clock;

  switch_input_arbiter #(.NUM_REQ(NR), .GAP_CYCLES(GAP)) u_dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .sw_data(sw_data), .sw_enable(sw_enable), .grant_id(grant_id),
    .busy(busy), .pkt_done(pkt_done), .underrun(underrun));

  switch_input_arbiter #(.NUM_REQ(NR), .GAP_CYCLES(0)) u_gap0 (
    .clock(clock), .reset(reset), .req_valid(g_valid), .req_data(g_data),
    .req_ready(g0_ready), .sw_data(g0_data), .sw_enable(g0_en), .grant_id(g0_grant),
    .busy(g0_busy), .pkt_done(g0_done), .underrun(g0_under));

  switch_input_arbiter #(.NUM_REQ(NR), .GAP_CYCLES(3)) u_gap3 (
    .clock(clock), .reset(reset), .req_valid(g_valid), .req_data(g_data),
    .req_ready(g3_ready), .sw_data(g3_data), .sw_enable(g3_en), .grant_id(g3_grant),
    .busy(g3_busy), .pkt_done(g3_done), .underrun(g3_under));

  int checks = 0;
  int errors = 0;

  // Source-side byte streams (advance on real handshakes) and the model's own copy.
  logic [7:0] srcq [NR][$];
  logic [7:0] mq   [NR][$];
  int         drop [NR];
  bit         rand_mode = 1'b0;
  bit         t4_arm = 1'b0;

  // Reference model: 0 idle, 1 transferring a frame, 2 inter-frame gap.
  int         m_phase = 0;
  int         m_grant = 0;
  int         m_rr = 0;
  int         m_pos = 0;
  int         m_end = 0;
  int         m_gap = 0;
  logic [7:0] m_data = 8'h00;
  bit         m_en, m_done, m_under;

  int n_en, n_done, n_under;
  int done_log[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_byte(input int r, input logic [7:0] b);
    srcq[r].push_back(b);
    mq[r].push_back(b);
  endtask

  task automatic push_frame(input int r, input int len);
    push_byte(r, 8'($urandom));
    push_byte(r, 8'($urandom));
    push_byte(r, 8'(len));
    for (int i = 0; i < len; i++) push_byte(r, 8'($urandom));
    push_byte(r, 8'($urandom));
  endtask

  task automatic flush_all();
    for (int r = 0; r < int'(NR); r++) begin
      srcq[r].delete();
      mq[r].delete();
      drop[r] = 0;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < int'(NR); i++) begin
      req_valid[i] = (srcq[i].size() > 0) && (drop[i] == 0) &&
                     (!rand_mode || ($urandom_range(0, 3) != 0));
      req_data[i*8 +: 8] = (srcq[i].size() > 0) ? srcq[i][0] : 8'($urandom);
    end
  endtask

  task automatic model_update(input logic [NR-1:0] v);
    bit found;
    m_en = 1'b0; m_done = 1'b0; m_under = 1'b0;
    case (m_phase)
      0: begin
        found = 1'b0;
        for (int k = 0; k < int'(NR); k++) begin
          int idx;
          idx = (m_rr + k) % int'(NR);
          if (!found && v[idx]) begin
            found = 1'b1;
            m_grant = idx;
          end
        end
        if (found) begin
          m_rr = (m_grant + 1) % int'(NR);
          m_phase = 1;
          m_pos = 0;
          m_end = 1000;
        end
      end
      1: begin
        if (v[m_grant] && mq[m_grant].size() > 0) begin
          m_data = mq[m_grant].pop_front();
          m_en = 1'b1;
          if (m_pos == 2) m_end = int'(m_data) + 4;
          m_pos++;
          if (m_pos == m_end) begin
            m_done = 1'b1;
            m_gap = GAP;
            m_phase = (GAP > 0) ? 2 : 0;
          end
        end else begin
          m_under = 1'b1;
        end
      end
      default: begin
        m_gap--;
        if (m_gap == 0) m_phase = 0;
      end
    endcase
  endtask

  // One clock: drive at posedge+1, check ready before the edge, outputs 1 after it.
  task automatic cycle();
    logic [NR-1:0] v, rdy, er;
    drive();
    #1;
    v = req_valid;
    rdy = req_ready;
    er = '0;
    if (m_phase == 1) er[m_grant] = 1'b1;
    check("req_ready", 32'(rdy), 32'(er));
    check("ready_onehot0", 32'($onehot0(rdy)), 32'd1);
    @(posedge clock);
    for (int i = 0; i < int'(NR); i++) begin
      if (v[i] && rdy[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
    end
    model_update(v);
    for (int i = 0; i < int'(NR); i++) if (drop[i] > 0) drop[i]--;
    if (t4_arm && m_phase == 1 && m_grant == 1 && m_pos == 4) begin
      drop[1] = 3;
      t4_arm = 1'b0;
    end
    #1;
    check("sw_enable", 32'(sw_enable), 32'(m_en));
    check("sw_data", 32'(sw_data), 32'(m_data));
    check("pkt_done", 32'(pkt_done), 32'(m_done));
    check("underrun", 32'(underrun), 32'(m_under));
    check("grant_id", 32'(grant_id), 32'(m_grant));
    check("busy", 32'(busy), 32'(m_phase == 1));
    if (sw_enable) n_en++;
    if (pkt_done) begin
      n_done++;
      done_log.push_back(int'(grant_id));
    end
    if (underrun) n_under++;
  endtask

  task automatic clear_stats();
    n_en = 0; n_done = 0; n_under = 0;
    done_log.delete();
  endtask

  task automatic run_drain(input string tag, input int budget);
    int n = 0;
    bit pending = 1'b1;
    while (pending && n < budget) begin
      cycle();
      n++;
      pending = (m_phase != 0);
      for (int r = 0; r < int'(NR); r++) if (srcq[r].size() > 0) pending = 1'b1;
    end
    check(tag, 32'(n < budget), 32'd1);
    cycle();
    cycle();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_en"}, 32'(sw_enable), 32'd0);
    check({tag, "_data"}, 32'(sw_data), 32'd0);
    check({tag, "_grant"}, 32'(grant_id), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(pkt_done), 32'd0);
    check({tag, "_under"}, 32'(underrun), 32'd0);
    check({tag, "_ready"}, 32'(req_ready), 32'd0);
  endtask

  task automatic check_gap(input string tag, input logic [59:0] e, input int gap);
    int i = 0;
    int runlen;
    logic cur;
    while (i < 60 && !e[i]) i++;
    while (i < 60) begin
      cur = e[i];
      runlen = 0;
      while (i < 60 && e[i] == cur) begin
        runlen++;
        i++;
      end
      if (i < 60) check(tag, 32'(runlen), cur ? 32'd4 : 32'(gap + 1));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [59:0] e0, e3;
    int n;
    reset = 1'b1;
    req_valid = '0;
    req_data = '0;
    g_valid = '0;
    g_data = '0;
    flush_all();
    clear_stats();
    #12;
    check_zero("reset");
    #1 reset = 1'b0;
    @(posedge clock);
    #1;

    // All four valid, LENGTH=0: round-robin 0,1,2,3,0,... with 4-byte frames
    for (int f = 0; f < 2; f++) for (int r = 0; r < int'(NR); r++) push_frame(r, 0);
    run_drain("t2_drain", 400);
    check("t2_frames", 32'(done_log.size()), 32'd8);
    for (int k = 0; k < done_log.size(); k++) check("t2_order", 32'(done_log[k]), 32'(k % 4));
    check("t2_bytes", 32'(n_en), 32'd32);

    // Single fixed frame from requester 0
    clear_stats();
    push_byte(0, 8'h11); push_byte(0, 8'h22); push_byte(0, 8'h02);
    push_byte(0, 8'hA0); push_byte(0, 8'hA1); push_byte(0, 8'h5C);
    run_drain("t1_drain", 100);
    check("t1_bytes", 32'(n_en), 32'd6);
    check("t1_done", 32'(n_done), 32'd1);
    check("t1_grant", 32'(grant_id), 32'd0);

    // Maximum LENGTH from requester 2
    clear_stats();
    push_frame(2, 255);
    run_drain("t3_drain", 1000);
    check("t3_bytes", 32'(n_en), 32'd259);
    check("t3_done", 32'(n_done), 32'd1);

    // Requester 1 drops valid for 3 cycles after payload byte 1
    clear_stats();
    push_frame(1, 4);
    t4_arm = 1'b1;
    run_drain("t4_drain", 100);
    check("t4_under", 32'(n_under), 32'd3);
    check("t4_bytes", 32'(n_en), 32'd8);
    check("t4_grant", 32'(grant_id), 32'd1);

    // Random traffic with random valid gaps
    clear_stats();
    rand_mode = 1'b1;
    for (int f = 0; f < 30; f++) push_frame($urandom_range(0, NR - 1), $urandom_range(0, 12));
    run_drain("rand_drain", 5000);
    check("rand_frames", 32'(n_done), 32'd30);
    rand_mode = 1'b0;

    // Reset in the middle of requester 3's payload
    clear_stats();
    push_frame(3, 20);
    n = 0;
    while (!(m_phase == 1 && m_grant == 3 && m_pos == 6) && n < 200) begin
      cycle();
      n++;
    end
    check("t5_reach", 32'(n < 200), 32'd1);
    #2 reset = 1'b1;
    req_valid = '0;
    #1;
    check_zero("t5_reset");
    flush_all();
    m_phase = 0; m_rr = 0; m_grant = 0; m_pos = 0; m_data = 8'h00;
    @(posedge clock);
    #3 reset = 1'b0;
    @(posedge clock);
    #1;
    push_frame(3, 2);
    push_frame(1, 2);
    run_drain("t5_drain", 200);
    check("t5_frames", 32'(done_log.size()), 32'd2);
    if (done_log.size() == 2) begin
      check("t5_first", 32'(done_log[0]), 32'd1);
      check("t5_second", 32'(done_log[1]), 32'd3);
    end

    // Gap builds: continuous LENGTH=0 frames from requester 0
    req_valid = '0;
    g_valid = 4'b0001;
    for (int c = 0; c < 60; c++) begin
      @(posedge clock);
      #1;
      e0[c] = g0_en;
      e3[c] = g3_en;
    end
    g_valid = '0;
    check_gap("gap0_run", e0, 0);
    check_gap("gap3_run", e3, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
